// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: groups the producer handshake and FIFO write side of
// the arbiter.
//   master : producers and FIFO, i.e. whatever sits around the arbiter
//   slave  : the arbiter itself
// Signals:
//   req_valid/req_data/req_ready : per-producer valid/ready handshake.
//     Producer i owns req_data[i*SIZE +: SIZE].
//   fifo_full   : FIFO almost-full, meaning at most one free entry remains.
//   fifo_w_en, fifo_w_data : registered FIFO write port.
//   grant_id, busy : current owner, and the flag that says a grant is active.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int SIZE    = 4
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*SIZE-1:0] req_data;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    fifo_full;
  logic                    fifo_w_en;
  logic [SIZE-1:0]         fifo_w_data;
  logic [IW-1:0]           grant_id;
  logic                    busy;

  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_w_en, fifo_w_data, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_w_en, fifo_w_data, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares a single FIFO write port among NUM_REQ producers.
// Arbitration is round-robin, and each grant is limited to MAX_BURST beats.
// Ports:
//   clk, rst_n : clock, and an asynchronous active-low reset.
//   bus        : fifo_wr_arbiter_if.slave, which carries the producer
//                handshake, the FIFO write port and the owner/busy status.
// Optional feature: define FIFO_ARB_FIXED_PRIO_EN to replace round-robin
// with fixed priority, where the lowest index wins. With this macro,
// last_grant is not built.
// Write data leaves one cycle after the handshake. This is why fifo_full
// must be an almost-full flag: a beat that is already in flight must still
// fit in the FIFO.

// Per-producer ready. The path is combinational from fifo_full and from the
// grant state.
module fifo_wr_arbiter_lane #(
  parameter int IW = 2,
  parameter int ID = 0
) (
  input  logic          granted,
  input  logic [IW-1:0] owner,
  input  logic          fifo_full,
  output logic          ready
);
  assign ready = granted && (owner == IW'(ID)) && !fifo_full;
endmodule

module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int SIZE      = 4,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  fifo_wr_arbiter_if.slave  bus
);
  localparam int         IW   = $clog2(NUM_REQ);
  localparam logic [3:0] LAST = 4'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state;
  logic [3:0]          beat_cnt;
  logic [IW-1:0]       win;
  logic                owner_vld;
  logic                xfer;
  logic [SIZE-1:0]     owner_data;
  logic [NUM_REQ-1:0]  ready;
`ifndef FIFO_ARB_FIXED_PRIO_EN
  logic [IW-1:0]       last_grant;
  int                  idx;
`endif

  assign owner_vld  = bus.req_valid[bus.grant_id];
  assign owner_data = bus.req_data[int'(bus.grant_id)*SIZE +: SIZE];
  assign xfer       = (state == GRANT) && owner_vld && !bus.fifo_full;
  assign bus.busy   = (state == GRANT);
  assign bus.req_ready = ready;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    fifo_wr_arbiter_lane #(.IW(IW), .ID(i)) u_lane (
      .granted  (state == GRANT),
      .owner    (bus.grant_id),
      .fifo_full(bus.fifo_full),
      .ready    (ready[i])
    );
  end

  // The winner search runs the loop downward, so the last hit is the
  // candidate nearest the start of the search order.
  always_comb begin
    win = '0;
`ifdef FIFO_ARB_FIXED_PRIO_EN
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (bus.req_valid[i]) win = IW'(i);
`else
    idx = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(last_grant) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (bus.req_valid[idx]) win = IW'(idx);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      beat_cnt        <= '0;
      bus.grant_id    <= '0;
      bus.fifo_w_en   <= 1'b0;
      bus.fifo_w_data <= '0;
`ifndef FIFO_ARB_FIXED_PRIO_EN
      last_grant      <= IW'(NUM_REQ - 1);
`endif
    end else begin
      bus.fifo_w_en <= xfer;
      if (xfer) bus.fifo_w_data <= owner_data;
      case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            state        <= GRANT;
            bus.grant_id <= win;
            beat_cnt     <= '0;
          end
        end
        GRANT: begin
          // While fifo_full is high, the state holds and the beat count
          // freezes. Dropping valid ends the grant, even while full.
          if (xfer) begin
            beat_cnt <= beat_cnt + 4'd1;
            if (beat_cnt == LAST) begin
              state <= IDLE;
`ifndef FIFO_ARB_FIXED_PRIO_EN
              last_grant <= bus.grant_id;
`endif
            end
          end else if (!owner_vld) begin
            state <= IDLE;
`ifndef FIFO_ARB_FIXED_PRIO_EN
            last_grant <= bus.grant_id;
`endif
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: a behavioural model predicts every output on every
// cycle. Directed scenarios pin the model with literal expectations, and a
// randomized phase with producer behaviour and a full flag follows them.
module tb_fifo_wr_arbiter;
  localparam int NUM_REQ = 4, SIZE = 4, MAX_BURST = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .SIZE(SIZE)) bus();
  fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .SIZE(SIZE), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_cmp = 0, n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---- behavioural model: owner is -1 when nobody holds the port ----
  int              m_owner, m_cnt, m_last, m_gid;
  logic            m_wen, m_x;
  logic [SIZE-1:0] m_wdata;

  function automatic int pick(input logic [NUM_REQ-1:0] v, input int last);
`ifdef FIFO_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= NUM_REQ; k++) if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
`endif
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_cnt = 0; m_last = NUM_REQ - 1; m_gid = 0;
      m_wen = 1'b0; m_wdata = '0;
    end else begin
      m_x = (m_owner >= 0) && bus.req_valid[m_owner] && !bus.fifo_full;
      m_wen = m_x;
      if (m_x) m_wdata = bus.req_data[m_owner*SIZE +: SIZE];
      if (m_owner < 0) begin
        if (bus.req_valid != '0) begin
          m_owner = pick(bus.req_valid, m_last); m_gid = m_owner; m_cnt = 0;
        end
      end else if (m_x) begin
        m_cnt++;
        if (m_cnt == MAX_BURST) begin
`ifndef FIFO_ARB_FIXED_PRIO_EN
          m_last = m_owner;
`endif
          m_owner = -1;
        end
      end else if (!bus.req_valid[m_owner]) begin
`ifndef FIFO_ARB_FIXED_PRIO_EN
        m_last = m_owner;
`endif
        m_owner = -1;
      end
    end
  end

  // ---- per-cycle compare against the model ----
  always @(negedge clk) begin
    if (chk_en) begin
      logic [NUM_REQ-1:0] exp_rdy;
      exp_rdy = '0;
      if (m_owner >= 0 && !bus.fifo_full) exp_rdy[m_owner] = 1'b1;
      chk("busy", 32'(bus.busy), 32'(m_owner >= 0));
      chk("w_en", 32'(bus.fifo_w_en), 32'(m_wen));
      chk("w_data", 32'(bus.fifo_w_data), 32'(m_wdata));
      chk("ready", 32'(bus.req_ready), 32'(exp_rdy));
      if (m_owner >= 0) chk("grant_id", 32'(bus.grant_id), 32'(m_gid));
    end
  end

  // FIFO-side capture for the directed checks.
  logic [SIZE-1:0] wq[$];
  always @(negedge clk)
    if (rst_n && bus.fifo_w_en) wq.push_back(bus.fifo_w_data);

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_busy"},  32'(bus.busy), 32'd0);
    chk({nm, "_wen"},   32'(bus.fifo_w_en), 32'd0);
    chk({nm, "_ready"}, 32'(bus.req_ready), 32'd0);
    chk({nm, "_gid"},   32'(bus.grant_id), 32'd0);
    chk({nm, "_wdata"}, 32'(bus.fifo_w_data), 32'd0);
  endtask

  initial begin
    logic [NUM_REQ-1:0]      v;
    logic [NUM_REQ*SIZE-1:0] d;
    logic [NUM_REQ-1:0]      xf, rs;
    bus.req_valid = '0; bus.req_data = '0; bus.fifo_full = 1'b0;
    #2 rst_n = 1'b0; chk_en = 1'b1;

    // Reset held with every producer valid, then all requesters streaming.
    bus.req_valid = 4'hF; bus.req_data = 16'h3210;
    tick(); tick();
    chk_reset_vals("rst");
    rst_n = 1'b1; wq.delete();
    tick();
    chk("first_busy", 32'(bus.busy), 32'd1);
    chk("first_gid", 32'(bus.grant_id), 32'd0);
    repeat (22) tick();
    chk("seq_len", 32'(wq.size() >= 17), 32'd1);
    for (int k = 0; k < 17 && k < wq.size(); k++) begin
`ifdef FIFO_ARB_FIXED_PRIO_EN
      chk("seq", 32'(wq[k]), 32'd0);
`else
      chk("seq", 32'(wq[k]), 32'((k / 4) % 4));
`endif
    end

    // Owner 2 sends A, B and then drops valid. Requester 1 is waiting.
    rst_pulse();
    bus.req_valid = 4'b0100; bus.req_data = 16'h0A50; wq.delete();
    tick();
    chk("o2_gid", 32'(bus.grant_id), 32'd2);
    bus.req_valid = 4'b0110;
    tick(); bus.req_data[11:8] = 4'hB;
    tick(); bus.req_valid = 4'b0010;
    tick(); tick();
    chk("o2_busy", 32'(bus.busy), 32'd1);
`ifdef FIFO_ARB_FIXED_PRIO_EN
    chk("o2_next", 32'(bus.grant_id), 32'd1);
`else
    chk("o2_next", 32'(bus.grant_id), 32'd1);
`endif
    chk("o2_cnt", 32'(wq.size()), 32'd2);
    if (wq.size() == 2) begin
      chk("o2_b0", 32'(wq[0]), 32'hA);
      chk("o2_b1", 32'(wq[1]), 32'hB);
    end

    // fifo_full is held high for 5 cycles after beat 2.
    rst_pulse();
    bus.req_valid = 4'b0001; bus.req_data = 16'h0001; wq.delete();
    tick();
    tick(); bus.req_data[3:0] = 4'd2;
    tick(); bus.req_data[3:0] = 4'd3; bus.fifo_full = 1'b1;
    repeat (5) begin
      tick();
      chk("full_ready", 32'(bus.req_ready), 32'd0);
      chk("full_wen", 32'(bus.fifo_w_en), 32'd0);
    end
    bus.fifo_full = 1'b0;
    tick(); bus.req_data[3:0] = 4'd4;
    tick(); bus.req_valid = '0;
    tick(); tick();
    chk("full_cnt", 32'(wq.size()), 32'd4);
    if (wq.size() == 4)
      for (int k = 0; k < 4; k++) chk("full_seq", 32'(wq[k]), 32'(k + 1));

    // Reset asserted during beat 3 of a burst.
    rst_pulse();
    bus.req_valid = 4'hF; bus.req_data = 16'h3210;
    repeat (4) tick();
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    tick(); rst_n = 1'b1;
    tick();
    chk("midrst_busy", 32'(bus.busy), 32'd1);
    chk("midrst_gid", 32'(bus.grant_id), 32'd0);

    // Single requester 1: bursts of 4 beats, each followed by a 1-cycle bubble.
    bus.req_valid = '0;
    tick(); tick();
    wq.delete(); bus.req_valid = 4'b0010; bus.req_data = 16'h0070;
    repeat (21) begin
      tick();
      if (bus.busy) chk("single_gid", 32'(bus.grant_id), 32'd1);
    end
    chk("single_cnt", 32'(wq.size()), 32'd16);
    bus.req_valid = '0;
    tick(); tick();

    // Randomized traffic: producers hold data until it is taken, sometimes
    // abandon a request, and see a random full flag.
    v = '0; d = '0;
    for (int it = 0; it < 3000; it++) begin
      @(negedge clk);
      rs = bus.req_ready;
      xf = bus.req_valid & rs;
      @(posedge clk); #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (v[i] && !xf[i]) begin
          if ($urandom_range(0, 19) == 0) v[i] = 1'b0;
        end else begin
          v[i] = ($urandom_range(0, 2) != 0);
          d[i*SIZE +: SIZE] = SIZE'($urandom);
        end
      end
      bus.req_valid = v; bus.req_data = d;
      bus.fifo_full = ($urandom_range(0, 3) == 0);
      rst_n = (it != 1500);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of a FIFO among NUM_REQ producers using round-robin arbitration with bounded bursts.
- Each producer uses a valid/ready handshake; the arbiter drives the FIFO's w_en/w_data and honours its full flag.
- Sits in front of the FIFO write side, in the FIFO write clock domain; single clock.

Parameters:
NUM_REQ, 4, number of producers (2..8)
SIZE, 4, data width per beat; matches FIFO data width
MAX_BURST, 4, maximum consecutive beats per grant (1..16)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-producer data valid
req_data  input  NUM_REQ*SIZE  producer data; producer i occupies bits [i*SIZE +: SIZE]
req_ready  output  NUM_REQ  per-producer ready; one-hot or zero
fifo_full  input  1  FIFO almost-full: high when at most 1 free entry remains
fifo_w_en  output  1  FIFO write enable, registered
fifo_w_data  output  SIZE  FIFO write data, registered
grant_id  output  clog2(NUM_REQ)  index of current owner; valid while busy=1
busy  output  1  high in GRANT state

Behaviour:
- Reset: clk and rst_n are the only clock and reset. Reset is asynchronous and active-low.
  - Values in reset: state=IDLE, req_ready=0, fifo_w_en=0, fifo_w_data=0, grant_id=0, busy=0, beat_cnt=0, last_grant=NUM_REQ-1. Requester 0 therefore wins first.
- States:
  - IDLE: if any req_valid is set, pick the winner and go to GRANT, registering owner/grant_id and clearing beat_cnt. Otherwise stay in IDLE.
  - GRANT: owner may transfer beats.
- Round-robin winner: first i with req_valid[i]=1, searching from last_grant+1 upward, wrapping modulo NUM_REQ.
- Ready rules:
  - req_ready[i] = (state==GRANT) && (i==owner) && !fifo_full. This path is combinational from fifo_full and state.
  - A transfer occurs when req_valid[owner] && req_ready[owner].
- Write latency:
  - On a transfer, fifo_w_en<=1 and fifo_w_data<=req_data[owner] at the next edge; otherwise fifo_w_en<=0.
  - fifo_w_data holds its last value when no transfer occurs.
  - One-cycle write latency. fifo_full must be almost-full so the in-flight beat always fits.
- Burst count: beat_cnt increments on each transfer and is 4 bits wide.
- Release from GRANT to IDLE, with last_grant<=owner, when either:
  - a transfer occurs with beat_cnt==MAX_BURST-1, or
  - req_valid[owner]=0 in GRANT (no transfer that cycle).
- Boundary conditions:
  - fifo_full high in GRANT: hold GRANT with no transfer. beat_cnt frozen, no timeout.
  - Owner drops valid while fifo_full is high: release as above.
  - Only one requester active: it is re-granted after a 1-cycle IDLE bubble, so sustained throughput is MAX_BURST beats per MAX_BURST+1 cycles.
  - Non-owner valid changes during GRANT are ignored.
  - Producer data is captured only on a transfer. Producers must hold data stable while valid and not ready.
- Reset mid-operation: all state cleared immediately. A beat transferred in the cycle before reset assertion is lost if fifo_w_en has not yet reached the FIFO.

Optional Feature:
- Macro: FIFO_ARB_FIXED_PRIO_EN
- When defined: the winner in IDLE is the lowest index with req_valid=1. last_grant is neither updated nor used. MAX_BURST still bounds grants.
- When undefined: round-robin as specified above.

Test Plan:
- Reset with all req_valid=1 -> busy=0, fifo_w_en=0, req_ready=0. After release: grant_id=0 on the 2nd edge; beats written at cycles 3..6; grant moves to 1.
- All 4 requesters continuously valid, MAX_BURST=4, data=requester index -> fifo_w_data sequence 0,0,0,0,1,1,1,1,2,...,3,0, with one idle cycle between bursts.
  - With FIFO_ARB_FIXED_PRIO_EN defined, the same stimulus gives only 0s.
- Owner 2 sends 2 beats (0xA, 0xB) then drops valid, while requester 1 is valid -> 2 writes of 0xA, 0xB. Next grant goes to 3 if valid, else wraps to 1.
- fifo_full asserted for 5 cycles mid-burst after beat 2 -> req_ready=0 and fifo_w_en=0 for those cycles. Burst resumes and finishes with exactly 2 more beats; no beat duplicated or lost.
- rst_n pulsed low during GRANT at beat 3 -> outputs return to reset values within the same cycle. After release, requester 0 wins first.
- Single requester 1 valid for 20 cycles -> grant_id stays 1. Writes follow the pattern 4 beats then 1 bubble, repeated; 16 writes in 20 cycles.
